// File: rtl/mult_pipe.sv
// Pipelined signed multiply / multiply-accumulate with arithmetic scaling,
// optional round-half-up, and saturation or wrap with an overflow flag.
module mult_pipe #(
    parameter int WIDTH_X   = 16,
    parameter int WIDTH_Y   = 16,
    parameter int WIDTH_OUT = 31,
    parameter int LATENCY   = 3,
    parameter int SHIFT     = 0,
    parameter int ROUND     = 0,
    parameter int SATURATE  = 1,
    parameter int ACC_EN    = 0,
    parameter int ACC_WIDTH = 40
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic signed [WIDTH_X-1:0]   x,
    input  logic signed [WIDTH_Y-1:0]   y,
    input  logic                        stb_in,
    input  logic                        acc_clear,
    output logic signed [WIDTH_OUT-1:0] product,
    output logic                        stb_out,
    output logic                        ovf
);

    localparam int PW = WIDTH_X + WIDTH_Y;
    localparam int SW = ACC_WIDTH + 1;
    localparam int CW = (SW > WIDTH_OUT) ? SW : WIDTH_OUT;
    localparam int NV = LATENCY - 2;

    logic signed [WIDTH_X-1:0] x_q;
    logic signed [WIDTH_Y-1:0] y_q;
    logic                      stb_q;
    logic                      clr_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            x_q   <= '0;
            y_q   <= '0;
            stb_q <= 1'b0;
            clr_q <= 1'b0;
        end else begin
            stb_q <= stb_in;
            clr_q <= stb_in & acc_clear;
            if (stb_in) begin
                x_q <= x;
                y_q <= y;
            end
        end
    end

    logic signed [PW-1:0]        prod_full;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] val_d;

    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        prod_full = PW'(x_q) * PW'(y_q);
        prod_ext  = ACC_WIDTH'(prod_full);
        acc_d     = acc_q;
        val_d     = prod_ext;
        if (ACC_EN != 0) begin
            if (stb_q) begin
                acc_d = clr_q ? prod_ext : acc_q + prod_ext;
            end
            val_d = acc_d;
        end
    end

    logic signed [ACC_WIDTH-1:0] val_q [NV];
    logic [NV-1:0]               vld_q;

    // NOTE: the delay line is reset element by element because in-flight
    // samples must vanish on reset, not just be marked invalid.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc_q <= '0;
            vld_q <= '0;
            for (int i = 0; i < NV; i++) begin
                val_q[i] <= '0;
            end
        end else begin
            acc_q    <= acc_d;
            vld_q[0] <= stb_q;
            val_q[0] <= val_d;
            for (int i = 1; i < NV; i++) begin
                vld_q[i] <= vld_q[i-1];
                val_q[i] <= val_q[i-1];
            end
        end
    end

    logic signed [ACC_WIDTH-1:0] val_last;
    logic signed [SW-1:0]        rnd_add;
    logic signed [SW-1:0]        sum;
    logic signed [SW-1:0]        scaled;
    logic signed [CW-1:0]        s_w;
    logic signed [CW-1:0]        max_w;
    logic signed [CW-1:0]        min_w;
    logic                        in_range;
    logic                        stb_d;
    logic                        ovf_d;
    logic signed [WIDTH_OUT-1:0] product_d;

    // One extra bit of headroom lets the rounding constant be added without overflow.
    always_comb begin
        val_last = val_q[NV-1];
        rnd_add  = '0;
        if (ROUND != 0) begin
            rnd_add = (SW'(1) << SHIFT) >> 1;
        end
        sum      = SW'(val_last) + rnd_add;
        scaled   = sum >>> SHIFT;
        s_w      = CW'(scaled);
        max_w    = '0;
        max_w[WIDTH_OUT-2:0] = '1;
        min_w    = ~max_w;
        in_range = (s_w <= max_w) && (s_w >= min_w);

        stb_d     = vld_q[NV-1];
        ovf_d     = 1'b0;
        product_d = '0;
        if (stb_d) begin
            product_d = s_w[WIDTH_OUT-1:0];
            if (!in_range) begin
                ovf_d = 1'b1;
                if (SATURATE != 0) begin
                    product_d = (s_w > max_w) ? max_w[WIDTH_OUT-1:0] : min_w[WIDTH_OUT-1:0];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            product <= '0;
            stb_out <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            product <= product_d;
            stb_out <= stb_d;
            ovf     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mult_pipe.sv
// Bench for mult_pipe: seven parameter sets share one stimulus stream and are
// compared every cycle against an arithmetic reference model.
module tb_mult_pipe;

    localparam int NC = 7;
    localparam int C_W   [NC] = '{31, 31, 16, 16, 31, 31, 31};
    localparam int C_LAT [NC] = '{3, 3, 3, 3, 3, 5, 8};
    localparam int C_SH  [NC] = '{0, 0, 15, 15, 0, 0, 0};
    localparam int C_RND [NC] = '{0, 0, 1, 0, 0, 0, 0};
    localparam int C_SAT [NC] = '{1, 0, 1, 1, 1, 1, 1};
    localparam int C_ACC [NC] = '{0, 0, 0, 0, 1, 1, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n;
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic               stb_in;
    logic               acc_clear;
    logic signed [30:0] p0, p1, p4, p5, p6;
    logic signed [15:0] p2, p3;
    logic [NC-1:0]      so;
    logic [NC-1:0]      ov;
    longint             obs_prod [NC];

    assign obs_prod[0] = longint'(p0);
    assign obs_prod[1] = longint'(p1);
    assign obs_prod[2] = longint'(p2);
    assign obs_prod[3] = longint'(p3);
    assign obs_prod[4] = longint'(p4);
    assign obs_prod[5] = longint'(p5);
    assign obs_prod[6] = longint'(p6);

    mult_pipe u0 (.clock(clk), .reset_n(reset_n), .x(x), .y(y), .stb_in(stb_in),
                  .acc_clear(acc_clear), .product(p0), .stb_out(so[0]), .ovf(ov[0]));
    mult_pipe #(.SATURATE(0)) u1 (.clock(clk), .reset_n(reset_n), .x(x), .y(y), .stb_in(stb_in),
                  .acc_clear(acc_clear), .product(p1), .stb_out(so[1]), .ovf(ov[1]));
    mult_pipe #(.WIDTH_OUT(16), .SHIFT(15), .ROUND(1)) u2 (.clock(clk), .reset_n(reset_n), .x(x),
                  .y(y), .stb_in(stb_in), .acc_clear(acc_clear), .product(p2), .stb_out(so[2]),
                  .ovf(ov[2]));
    mult_pipe #(.WIDTH_OUT(16), .SHIFT(15), .ROUND(0)) u3 (.clock(clk), .reset_n(reset_n), .x(x),
                  .y(y), .stb_in(stb_in), .acc_clear(acc_clear), .product(p3), .stb_out(so[3]),
                  .ovf(ov[3]));
    mult_pipe #(.ACC_EN(1), .LATENCY(3)) u4 (.clock(clk), .reset_n(reset_n), .x(x), .y(y),
                  .stb_in(stb_in), .acc_clear(acc_clear), .product(p4), .stb_out(so[4]), .ovf(ov[4]));
    mult_pipe #(.ACC_EN(1), .LATENCY(5)) u5 (.clock(clk), .reset_n(reset_n), .x(x), .y(y),
                  .stb_in(stb_in), .acc_clear(acc_clear), .product(p5), .stb_out(so[5]), .ovf(ov[5]));
    mult_pipe #(.ACC_EN(1), .LATENCY(8)) u6 (.clock(clk), .reset_n(reset_n), .x(x), .y(y),
                  .stb_in(stb_in), .acc_clear(acc_clear), .product(p6), .stb_out(so[6]), .ovf(ov[6]));

    // Reference model state: a result scheduled at the edge where it must be seen.
    int     cyc;
    int     edge_seen;
    longint acc_m   [NC];
    longint ev_prod [NC][16];
    bit     ev_ovf  [NC][16];
    bit     ev_vld  [NC][16];
    longint exp_prod [NC];
    bit     exp_stb  [NC];
    bit     exp_ovf  [NC];
    int     checks;
    int     errors;

    // Drives one cycle, advances the model, and leaves exp_* holding the values
    // the DUTs must present at the next rising edge.
    task automatic step(input bit rst, input bit stb, input bit clr, input int xv, input int yv);
        longint p, v, sc, mx, mn, pr;
        bit     of;
        int     slot;
        reset_n   = ~rst;
        stb_in    = stb;
        acc_clear = clr;
        x         = 16'(xv);
        y         = 16'(yv);
        @(posedge clk);
        cyc++;
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                acc_m[c] = 0;
                for (int k = 0; k < 16; k++) ev_vld[c][k] = 1'b0;
            end
        end else if (stb) begin
            p = longint'(x) * longint'(y);
            for (int c = 0; c < NC; c++) begin
                v = p;
                if (C_ACC[c] != 0) begin
                    acc_m[c] = clr ? p : acc_m[c] + p;
                    acc_m[c] = (acc_m[c] <<< 24) >>> 24;
                    v = acc_m[c];
                end
                if (C_RND[c] != 0 && C_SH[c] > 0) v = v + (longint'(1) <<< (C_SH[c] - 1));
                sc = v >>> C_SH[c];
                mx = (longint'(1) <<< (C_W[c] - 1)) - 1;
                mn = -mx - 1;
                of = (sc > mx) || (sc < mn);
                if (!of) pr = sc;
                else if (C_SAT[c] != 0) pr = (sc > mx) ? mx : mn;
                else pr = (sc <<< (64 - C_W[c])) >>> (64 - C_W[c]);
                slot = (cyc + C_LAT[c]) % 16;
                ev_vld[c][slot]  = 1'b1;
                ev_prod[c][slot] = pr;
                ev_ovf[c][slot]  = of;
            end
        end
        @(negedge clk);
        edge_seen = cyc + 1;
        slot = edge_seen % 16;
        for (int c = 0; c < NC; c++) begin
            exp_stb[c]  = ev_vld[c][slot];
            exp_prod[c] = ev_vld[c][slot] ? ev_prod[c][slot] : 0;
            exp_ovf[c]  = ev_vld[c][slot] ? ev_ovf[c][slot] : 1'b0;
            ev_vld[c][slot] = 1'b0;
        end
    endtask

    function automatic int rand_op();
        case ($urandom % 4)
            0:       return -32768;
            1:       return 32767;
            default: return int'($urandom);
        endcase
    endfunction

    task automatic test_reset();
        int k0;
        int first [NC];
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'($urandom), rand_op(), rand_op());
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (so[c] !== 1'b0 || obs_prod[c] !== 0 || ov[c] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset cfg%0d edge%0d: got stb=%b prod=%0d ovf=%b, want all 0",
                             c, edge_seen, so[c], obs_prod[c], ov[c]);
                end
            end
        end
        step(1'b0, 1'b1, 1'b1, 3, -5);
        k0 = cyc;
        for (int c = 0; c < NC; c++) first[c] = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'b0, 0, 0);
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (so[c] !== exp_stb[c] || obs_prod[c] !== exp_prod[c] || ov[c] !== exp_ovf[c]) begin
                    errors++;
                    $display("FAIL release cfg%0d edge%0d: got %b/%0d/%b want %b/%0d/%b", c, edge_seen,
                             so[c], obs_prod[c], ov[c], exp_stb[c], exp_prod[c], exp_ovf[c]);
                end
                if (so[c] === 1'b1 && first[c] < 0) first[c] = edge_seen;
            end
        end
        for (int c = 0; c < NC; c++) begin
            checks++;
            if (first[c] - k0 != C_LAT[c]) begin
                errors++;
                $display("FAIL latency cfg%0d: got %0d want %0d", c, first[c] - k0, C_LAT[c]);
            end
        end
    endtask

    task automatic test_multiply();
        int ks;
        step(1'b0, 1'b1, 1'b0, 3, -5);
        ks = cyc;
        for (int i = 0; i < 28; i++) begin
            if (i == 8) ks = cyc + 1;
            if (i < 8) step(1'b0, 1'b0, 1'b0, 0, 0);
            else step(1'b0, i < 18, 1'b0, i - 8, 2);
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (so[c] !== exp_stb[c] || obs_prod[c] !== exp_prod[c] || ov[c] !== exp_ovf[c]) begin
                    errors++;
                    $display("FAIL multiply cfg%0d edge%0d: got %b/%0d/%b want %b/%0d/%b", c, edge_seen,
                             so[c], obs_prod[c], ov[c], exp_stb[c], exp_prod[c], exp_ovf[c]);
                end
            end
            if (i < 8 && edge_seen == ks + 3) begin
                checks++;
                if (so[0] !== 1'b1 || obs_prod[0] !== -15) begin
                    errors++;
                    $display("FAIL single_3x-5: got stb=%b prod=%0d want stb=1 prod=-15", so[0], obs_prod[0]);
                end
            end
            if (i >= 8 && edge_seen >= ks + 3 && edge_seen < ks + 13) begin
                checks++;
                if (so[0] !== 1'b1 || obs_prod[0] !== longint'(2 * (edge_seen - ks - 3))) begin
                    errors++;
                    $display("FAIL stream: got stb=%b prod=%0d want stb=1 prod=%0d", so[0], obs_prod[0],
                             2 * (edge_seen - ks - 3));
                end
            end
        end
    endtask

    task automatic test_overflow();
        int ks;
        ks = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, i < 2, 1'b0, (i == 0) ? -32768 : 32767, (i == 0) ? -32768 : 32767);
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (so[c] !== exp_stb[c] || obs_prod[c] !== exp_prod[c] || ov[c] !== exp_ovf[c]) begin
                    errors++;
                    $display("FAIL overflow cfg%0d edge%0d: got %b/%0d/%b want %b/%0d/%b", c, edge_seen,
                             so[c], obs_prod[c], ov[c], exp_stb[c], exp_prod[c], exp_ovf[c]);
                end
            end
            if (edge_seen == ks + 3) begin
                checks++;
                if (obs_prod[0] !== 1073741823 || ov[0] !== 1'b1 || obs_prod[1] !== -1073741824 || ov[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL min_squared: got sat=%0d/%b wrap=%0d/%b want 1073741823/1 -1073741824/1",
                             obs_prod[0], ov[0], obs_prod[1], ov[1]);
                end
            end
            if (edge_seen == ks + 4) begin
                checks++;
                if (obs_prod[0] !== 1073676289 || ov[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL max_squared: got %0d/%b want 1073676289/0", obs_prod[0], ov[0]);
                end
            end
        end
    endtask

    task automatic test_scaling();
        int     ks;
        int     xs   [3] = '{16384, 1, -1};
        longint want2[3] = '{8192, 1, 0};
        longint want3[3] = '{8192, 0, -1};
        ks = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, i < 3, 1'b0, xs[i % 3], 16384);
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (so[c] !== exp_stb[c] || obs_prod[c] !== exp_prod[c] || ov[c] !== exp_ovf[c]) begin
                    errors++;
                    $display("FAIL scaling cfg%0d edge%0d: got %b/%0d/%b want %b/%0d/%b", c, edge_seen,
                             so[c], obs_prod[c], ov[c], exp_stb[c], exp_prod[c], exp_ovf[c]);
                end
            end
            if (edge_seen >= ks + 3 && edge_seen < ks + 6) begin
                checks++;
                if (obs_prod[2] !== want2[edge_seen - ks - 3] || obs_prod[3] !== want3[edge_seen - ks - 3]) begin
                    errors++;
                    $display("FAIL shift15: got round=%0d trunc=%0d want %0d %0d", obs_prod[2], obs_prod[3],
                             want2[edge_seen - ks - 3], want3[edge_seen - ks - 3]);
                end
            end
        end
    endtask

    task automatic test_accumulate();
        int     ks;
        int     j;
        bit     pat [10] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
        bit     clr [10] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        longint tbl [10] = '{10000, 20000, 30000, 40000, 0, 0, 0, 50000, 60000, 10000};
        ks = cyc + 1;
        for (int i = 0; i < 20; i++) begin
            if (i < 10) step(1'b0, pat[i], clr[i], 100, 100);
            else step(1'b0, 1'b0, 1'b0, 0, 0);
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (so[c] !== exp_stb[c] || obs_prod[c] !== exp_prod[c] || ov[c] !== exp_ovf[c]) begin
                    errors++;
                    $display("FAIL accumulate cfg%0d edge%0d: got %b/%0d/%b want %b/%0d/%b", c, edge_seen,
                             so[c], obs_prod[c], ov[c], exp_stb[c], exp_prod[c], exp_ovf[c]);
                end
            end
            if (edge_seen >= ks + 3 && edge_seen < ks + 13) begin
                j = edge_seen - ks - 3;
                checks++;
                if (so[4] !== pat[j] || obs_prod[4] !== tbl[j]) begin
                    errors++;
                    $display("FAIL acc_sum step%0d: got stb=%b prod=%0d want stb=%b prod=%0d", j, so[4],
                             obs_prod[4], pat[j], tbl[j]);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        int r;
        int ks;
        r  = cyc + 7;
        ks = cyc + 10;
        for (int i = 0; i < 22; i++) begin
            if (i < 6) step(1'b0, 1'b1, i == 0, rand_op(), rand_op());
            else if (i == 6) step(1'b1, 1'b1, 1'b0, 5, 5);
            else if (i == 9) step(1'b0, 1'b1, 1'b0, 2, 3);
            else step(1'b0, 1'b0, 1'b0, 0, 0);
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (so[c] !== exp_stb[c] || obs_prod[c] !== exp_prod[c] || ov[c] !== exp_ovf[c]) begin
                    errors++;
                    $display("FAIL midreset cfg%0d edge%0d: got %b/%0d/%b want %b/%0d/%b", c, edge_seen,
                             so[c], obs_prod[c], ov[c], exp_stb[c], exp_prod[c], exp_ovf[c]);
                end
            end
            for (int c = 4; c < NC; c++) begin
                if (edge_seen > r && edge_seen < ks + C_LAT[c]) begin
                    checks++;
                    if (so[c] !== 1'b0) begin
                        errors++;
                        $display("FAIL flushed cfg%0d edge%0d: got stb=%b want 0", c, edge_seen, so[c]);
                    end
                end else if (edge_seen == ks + C_LAT[c]) begin
                    checks++;
                    if (so[c] !== 1'b1 || obs_prod[c] !== 6) begin
                        errors++;
                        $display("FAIL post_reset cfg%0d: got stb=%b prod=%0d want stb=1 prod=6", c, so[c],
                                 obs_prod[c]);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(($urandom % 100) == 0, ($urandom % 10) < 7, ($urandom % 5) == 0, rand_op(), rand_op());
            for (int c = 0; c < NC; c++) begin
                checks++;
                if (so[c] !== exp_stb[c] || obs_prod[c] !== exp_prod[c] || ov[c] !== exp_ovf[c]) begin
                    errors++;
                    $display("FAIL random cfg%0d edge%0d: got %b/%0d/%b want %b/%0d/%b", c, edge_seen,
                             so[c], obs_prod[c], ov[c], exp_stb[c], exp_prod[c], exp_ovf[c]);
                end
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        edge_seen = 0;
        reset_n   = 1'b0;
        stb_in    = 1'b0;
        acc_clear = 1'b0;
        x         = '0;
        y         = '0;
        for (int c = 0; c < NC; c++) begin
            acc_m[c] = 0;
            for (int k = 0; k < 16; k++) ev_vld[c][k] = 1'b0;
        end
        test_reset();
        test_multiply();
        test_overflow();
        test_scaling();
        test_accumulate();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
